serial_eq_checker: RTL and testbench

SERIAL_EQ_CHECKER -- requirements
Module: serial_eq_checker

---
 rtl/serial_eq_checker_pkg.sv | 16 +
 rtl/xnor_gate.sv | 10 +
 rtl/serial_eq_checker.sv | 130 +++++++++++++
 tb/tb_serial_eq_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_eq_checker_pkg.sv
// Shared types and helpers for the serial equality checker.
package serial_eq_checker_pkg;

  // Frame control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of an index into a WIDTH-pair frame (at least one bit).
  function automatic int unsigned idx_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/xnor_gate.sv
// One-bit equality primitive: y = a XNOR b.
module xnor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/serial_eq_checker.sv
// Serial frame comparator: accepts WIDTH a/b bit pairs (LSB first) and
// reports whether every pair matched, plus the index of the first mismatch.
module serial_eq_checker
  import serial_eq_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          bit_valid,
  input  logic                          a,
  input  logic                          b,
  output logic                          bit_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          eq,
  output logic [idx_width(WIDTH)-1:0]   mismatch_idx
);

  localparam int unsigned      IDX_W    = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             seen_q, seen_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             eq_q, eq_d;
  logic [IDX_W-1:0] mis_q, mis_d;
  logic             bit_ready_q, bit_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_eq;

  // Per-pair equality from the shared one-bit primitive.
  xnor_gate u_xnor (
    .a (a),
    .b (b),
    .y (bit_eq)
  );

  // Next-state, accumulation, first-mismatch capture and result update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    seen_d  = seen_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    mis_d   = mis_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = 1'b1;
          seen_d  = 1'b0;
          idx_d   = '0;
        end
      end
      RUN: begin
        // Abort beats a pair presented in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (bit_valid) begin
          acc_d = acc_q & bit_eq;
          if (!bit_eq && !seen_q) begin
            seen_d = 1'b1;
            idx_d  = cnt_q;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            eq_d    = acc_d;
            mis_d   = idx_d;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state's decode.
    bit_ready_d = (state_d == RUN);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= 1'b1;
      seen_q      <= 1'b0;
      idx_q       <= '0;
      eq_q        <= 1'b0;
      mis_q       <= '0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      seen_q      <= seen_d;
      idx_q       <= idx_d;
      eq_q        <= eq_d;
      mis_q       <= mis_d;
      bit_ready_q <= bit_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bit_ready    = bit_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign eq           = eq_q;
  assign mismatch_idx = mis_q;

endmodule

// File: tb/tb_serial_eq_checker.sv
// Scoreboard bench for serial_eq_checker (WIDTH=8).
module tb_serial_eq_checker;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          bit_valid = 1'b0;
  logic          a = 1'b0;
  logic          b = 1'b0;
  logic          bit_ready;
  logic          busy;
  logic          done;
  logic          eq;
  logic [IW-1:0] mismatch_idx;

  typedef struct {
    logic e_eq;
    int   e_idx;
    int   e_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Reference model: 0 = idle, 1 = collecting pairs, 2 = result cycle.
  int   m_state = 0;
  logic qa[$];
  logic qb[$];
  logic h_eq = 1'b0;
  logic p_eq = 1'b0;
  int   h_idx = 0;
  int   p_idx = 0;

  serial_eq_checker #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .bit_valid    (bit_valid),
    .a            (a),
    .b            (b),
    .bit_ready    (bit_ready),
    .busy         (busy),
    .done         (done),
    .eq           (eq),
    .mismatch_idx (mismatch_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Frame result from the collected operands: equal if all pairs equal,
  // index of the lowest differing pair, else 0.
  function automatic void frame_result();
    p_eq  = 1'b1;
    p_idx = 0;
    for (int i = 0; i < int'(W); i++) begin
      if (qa[i] !== qb[i]) begin
        if (p_eq) p_idx = i;
        p_eq = 1'b0;
      end
    end
    sb.push_back('{p_eq, p_idx, cyc + 1});
  endfunction

  // One clock of stimulus: check status at the negedge, drive, advance model.
  task automatic step(input logic st, input logic ab, input logic v,
                      input logic ia, input logic ib);
    @(negedge clk);
    if (m_state == 2) begin
      h_eq  = p_eq;
      h_idx = p_idx;
    end
    check("bit_ready", int'(bit_ready), int'(m_state == 1));
    check("busy", int'(busy), int'(m_state != 0));
    check("eq_hold", int'(eq), int'(h_eq));
    check("idx_hold", int'(mismatch_idx), h_idx);
    start     = st;
    abort     = ab;
    bit_valid = v;
    a         = ia;
    b         = ib;
    case (m_state)
      0: begin
        if (st) begin
          qa.delete();
          qb.delete();
          m_state = 1;
        end
      end
      1: begin
        if (ab) begin
          m_state = 0;
        end else if (v) begin
          qa.push_back(ia);
          qb.push_back(ib);
          if (qa.size() == W) begin
            frame_result();
            m_state = 2;
          end
        end
      end
      default: m_state = 0;
    endcase
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0;
    #1;
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(bit_ready), 0);
    check("rst_eq", int'(eq), 0);
    check("rst_idx", int'(mismatch_idx), 0);
    m_state = 0;
    qa.delete();
    qb.delete();
    sb.delete();
    h_eq  = 1'b0;
    h_idx = 0;
    @(negedge clk);
    check("rst_done_hold", int'(done), 0);
    rst_n = 1'b1;
  endtask

  // Full frame; mode 0 = back-to-back, 1 = every other cycle, 2 = random gaps.
  // noise sprinkles start pulses while busy.
  task automatic send_frame(input logic [W-1:0] fa, input logic [W-1:0] fb,
                            input int mode, input bit noise);
    int   i;
    int   k;
    logic v;
    logic st;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    i = 0;
    k = 0;
    while (i < int'(W)) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (k % 2 == 1);
      else                v = ($urandom_range(2) != 0);
      st = noise && ($urandom_range(2) == 0);
      if (v) step(st, 1'b0, 1'b1, fa[i], fb[i]);
      else   step(st, 1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      if (v) i++;
      k++;
    end
    step(noise, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_eq", int'(eq), int'(e.e_eq));
          check("done_idx", int'(mismatch_idx), e.e_idx);
          check("done_cycle", cyc, e.e_cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    do_reset();

    // All-match frame, back-to-back.
    send_frame(8'b1011_0011, 8'b1011_0011, 0, 1'b0);
    // Single differing bit, valid every other cycle.
    send_frame(8'hA5, 8'hA1, 1, 1'b0);
    // Two mismatches: the first one is kept.
    send_frame(8'h00, 8'h81, 0, 1'b0);

    // Abort after 4 pairs with a pair presented; results keep previous frame.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8'h1C, 0, 1'b0);

    // Reset after 5 pairs; then start with a pair presented in IDLE.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < int'(W); i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start pulses in RUN and in the DONE cycle are ignored.
    send_frame(8'hF0, 8'h70, 0, 1'b1);

    // Start together with abort in IDLE: start wins.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(W); i++) step(1'b0, 1'b0, 1'b1, 1'(i == 6), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized frames with gaps, start noise and occasional aborts.
    for (int f = 0; f < 30; f++) begin
      ra = W'($urandom);
      rb = ($urandom_range(2) == 0) ? ra : (ra ^ W'($urandom));
      if ($urandom_range(3) == 0) begin
        n = $urandom_range(W - 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++)
          step(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        step(1'b0, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      send_frame(ra, rb, 2, 1'b1);
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pending_done", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
